// File: rtl/fetch_queue.sv
// Instruction fetch unit: one outstanding imem request, {pc, instr} FIFO toward decode, redirect flush/squash.
// Optional JAL next-PC prediction is enabled by defining FETCH_JAL_PREDICT_EN.
module fetch_queue #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(32'h6000_0000),
    parameter int               IQ_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            br_en,
    input  logic [XLEN-1:0] br,
    input  logic            freeze,
    output logic [XLEN-1:0] imem_addr,
    output logic [3:0]      imem_rmask,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_resp,
    output logic            iq_valid,
    input  logic            iq_ready,
    output logic [XLEN-1:0] iq_pc,
    output logic [31:0]     iq_instr,
    output logic            iq_pred_taken
);
    localparam int PW = $clog2(IQ_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(IQ_DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, BUSY_SQ} state_t;

    state_t          state_reg, state_next;
    logic [XLEN-1:0] addr_reg, addr_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    logic [PW-1:0]   head_reg, tail_reg;
    logic [CW-1:0]   count_reg, count_next, count_after;
    logic [XLEN-1:0] pc_mem [IQ_DEPTH];
    logic [31:0]     instr_mem [IQ_DEPTH];
    logic            enq, deq;
    logic [XLEN-1:0] seq_pc;

`ifdef FETCH_JAL_PREDICT_EN
    logic            pred_mem [IQ_DEPTH];
    logic            resp_jal;
    logic [XLEN-1:0] jal_imm;

    assign resp_jal = (imem_rdata[6:0] == 7'b1101111);
    assign jal_imm  = {{(XLEN-20){imem_rdata[31]}}, imem_rdata[19:12], imem_rdata[20],
                       imem_rdata[30:21], 1'b0};
    assign seq_pc   = addr_reg + (resp_jal ? jal_imm : XLEN'(4));
`else
    assign seq_pc   = addr_reg + XLEN'(4);
`endif

    // Responses are only captured in BUSY; BUSY_SQ responses belong to a squashed fetch.
    assign deq         = (count_reg != '0) && iq_ready;
    assign enq         = (state_reg == BUSY) && imem_resp && !br_en;
    assign count_after = count_reg + CW'(enq) - CW'(deq);

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        pc_next    = pc_reg;
        count_next = br_en ? '0 : count_after;
        case (state_reg)
            IDLE: begin
                if (br_en)
                    pc_next = br;
                if (!freeze && count_next < DEPTH_C) begin
                    addr_next  = br_en ? br : pc_reg;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (imem_resp) begin
                    if (br_en) begin
                        addr_next  = br;
                        pc_next    = br;
                        state_next = freeze ? IDLE : BUSY;
                    end else begin
                        pc_next = seq_pc;
                        if (!freeze && count_next < DEPTH_C)
                            addr_next = seq_pc;
                        else
                            state_next = IDLE;
                    end
                end else if (br_en) begin
                    pc_next    = br;
                    state_next = BUSY_SQ;
                end
            end
            BUSY_SQ: begin
                if (br_en)
                    pc_next = br;
                if (imem_resp) begin
                    addr_next  = br_en ? br : pc_reg;
                    state_next = freeze ? IDLE : BUSY;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            addr_reg  <= RESET_PC;
            pc_reg    <= RESET_PC;
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            pc_reg    <= pc_next;
            count_reg <= count_next;
            if (br_en) begin
                head_reg <= tail_reg;
            end else begin
                if (enq) tail_reg <= tail_reg + 1'b1;
                if (deq) head_reg <= head_reg + 1'b1;
            end
        end
    end

    // Storage carries no reset; the head is masked by iq_valid.
    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem[tail_reg]    <= addr_reg;
            instr_mem[tail_reg] <= imem_rdata;
`ifdef FETCH_JAL_PREDICT_EN
            pred_mem[tail_reg]  <= resp_jal;
`endif
        end
    end

    assign imem_addr  = addr_reg;
    assign imem_rmask = (state_reg != IDLE) ? 4'hF : 4'h0;
    assign iq_valid   = (count_reg != '0);
    assign iq_pc      = iq_valid ? pc_mem[head_reg] : '0;
    assign iq_instr   = iq_valid ? instr_mem[head_reg] : '0;
`ifdef FETCH_JAL_PREDICT_EN
    assign iq_pred_taken = iq_valid && pred_mem[head_reg];
`else
    assign iq_pred_taken = 1'b0;
`endif
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised next-generation instruction fetch unit. It sits between the instruction cache port and decode/dispatch.
- Keeps a fetch PC and issues one outstanding imem request at a time, holding each request stable until imem_resp.
- Buffers each returned {pc, instr} pair in an IQ_DEPTH-entry FIFO that decode drains with a valid/ready handshake.
- A branch redirect flushes the FIFO and squashes any in-flight response.

Parameters:
- RESET_PC, 32'h6000_0000, first fetch address after reset.
- IQ_DEPTH, 4, instruction queue entries; power of two, >=2.
- XLEN, 32, PC/instruction width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- br_en  in  1  redirect strobe, single cycle.
- br  in  XLEN  redirect target; valid when br_en=1.
- freeze  in  1  suppress issue of new requests; an outstanding request still completes.
- imem_addr  out  XLEN  request address; registered.
- imem_rmask  out  4  4'hF while a request is outstanding, else 4'h0.
- imem_rdata  in  32  instruction word; valid with imem_resp.
- imem_resp  in  1  response strobe for the outstanding request.
- iq_valid  out  1  queue head valid.
- iq_ready  in  1  decode accepts the head.
- iq_pc  out  XLEN  PC of the head entry.
- iq_instr  out  32  instruction of the head entry.
- iq_pred_taken  out  1  head was predicted taken (optional feature), else 0.

Behaviour:
- Registers: addr_q (outstanding address), pc_q (next fetch PC), FIFO with head/tail/count, state.
- States:
  - IDLE: no request outstanding.
  - BUSY: request outstanding.
  - BUSY_SQ: request outstanding, its response will be dropped.
- Outputs: imem_addr = addr_q. imem_rmask = 4'hF in BUSY/BUSY_SQ, else 0.
- Reset, applied any cycle including mid-request:
  - state=IDLE, pc_q=RESET_PC, addr_q=RESET_PC, count=0, head=tail=0.
  - Outputs: iq_valid=0, imem_rmask=0, iq_pc=0, iq_instr=0, iq_pred_taken=0.
  - A response arriving during or after reset for the pre-reset request is ignored. The memory side guarantees no stale resp after reset.
- IDLE:
  - br_en: pc_q<=br.
  - Otherwise, if !freeze and count<IQ_DEPTH (post-dequeue count): addr_q<=pc_q, ->BUSY.
  - br_en and issue in the same cycle: issue uses br directly.
- BUSY, imem_resp and no br_en:
  - Enqueue {addr_q, imem_rdata}; pc_q<=addr_q+4.
  - If !freeze and post-enqueue/dequeue count<IQ_DEPTH: addr_q<=addr_q+4, stay BUSY (back-to-back, one request per cycle with a 0-wait memory).
  - Otherwise ->IDLE.
- BUSY, br_en without imem_resp: pc_q<=br, flush FIFO, ->BUSY_SQ. addr_q and imem_rmask are held unchanged.
- BUSY, br_en with imem_resp: drop rdata, flush FIFO, addr_q<=br, pc_q<=br, stay BUSY (subject to freeze; ->IDLE if frozen).
- BUSY_SQ:
  - br_en: pc_q<=br.
  - imem_resp: drop rdata; addr_q<=(br_en ? br : pc_q); ->BUSY (->IDLE if freeze).
- Flush: count<=0, head=tail. A same-cycle dequeue is discarded. iq_valid=0 the cycle after br_en.
- Queue timing:
  - An enqueued entry is visible at iq_valid on the next cycle.
  - Dequeue occurs when iq_valid&&iq_ready.
  - Full queue: no issue, so no overflow is possible.
  - Empty queue: iq_valid=0 and iq_ready is ignored.
  - Pointers wrap modulo IQ_DEPTH.
- Arithmetic: PC adds are XLEN-bit, and 32'hFFFF_FFFC+4 wraps to 0.
- Invariant: at most one request is outstanding.

Optional Feature:
- Macro FETCH_JAL_PREDICT_EN.
- When defined, a response with imem_rdata[6:0]==7'b1101111 (JAL) sets the next fetch PC to addr_q + sign-extended J-immediate instead of +4. This applies to both the pc_q update and the back-to-back addr_q. The entry is enqueued with iq_pred_taken=1.
- When undefined: sequential +4 only, and iq_pred_taken is tied 0.

Test Plan:
- Reset, then iq_ready=1 and 0-wait memory returning resp the cycle after request -> imem_addr sequence 0x6000_0000, 0x6000_0004, 0x6000_0008; iq_pc matches, in order.
- iq_ready=0 with IQ_DEPTH=4 -> exactly 4 requests, then imem_rmask=0. One dequeue -> one new request at 0x6000_0010.
- br_en (br=0x6000_0100) while a request to 0x6000_0008 is outstanding with 3-cycle memory latency -> imem_addr held at 0x6000_0008 until resp, rdata dropped, next request 0x6000_0100, queue empty meanwhile.
- br_en same cycle as imem_resp -> response not enqueued, next request the following cycle at br.
- freeze=1 mid-stream -> the outstanding request completes and enqueues, then no further requests until freeze=0.
- FETCH_JAL_PREDICT_EN: JAL +0x20 at 0x6000_0004 -> next request 0x6000_0024, iq_pred_taken=1 on that entry.
